data_mem_controller: RTL and testbench

Arbitrates the data-memory requests of NUM_CONSUMERS load-store units onto a single external data-memory port. It sits directly downstream of the per-thread load-store units and upstream of the data memory. Each LSU uses a valid/ready handshake in which valid is held until a one-cycle ready. The controller grants one request at a time in round-robin order, forwards it to memory, waits for memory ready, and returns ready plus read data to the granted LSU.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/data_mem_controller_if.sv | 60 ++++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/data_mem_controller.sv | 178 +++++++++++++++++
 tb/tb_data_mem_controller.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared types and default widths for the data-memory
//               controller and its interface.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_NUM_CONSUMERS = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_WAIT  = 3'd1,
    ST_WRITE_WAIT = 3'd2,
    ST_ACK        = 3'd3,
    ST_RELEASE    = 3'd4
  } mem_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_controller_if
// Description : Bundles the per-LSU request/response buses and the single
//               external data-memory port.
//               master : controller view (drives consumer readys/read data
//                        and memory requests)
//               slave  : environment view (LSUs and data memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_controller_if
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS
) ();

  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: the first requesting index
//               at or after the pointer, wrapping around.
// Ports       : i_req         - request vector
//               i_rr_ptr      - index with highest priority this decision
//               o_grant_valid - at least one request present
//               o_grant       - chosen index (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CONSUMERS = 4
) (
  input  logic [NUM_CONSUMERS-1:0]         i_req,
  input  logic [$clog2(NUM_CONSUMERS)-1:0] i_rr_ptr,
  output logic                             o_grant_valid,
  output logic [$clog2(NUM_CONSUMERS)-1:0] o_grant
);

  localparam int GRANT_W = $clog2(NUM_CONSUMERS);

  int w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant       = '0;
    w_idx         = 0;
    // Scan from the farthest offset back to the pointer so the nearest
    // requester is the last one written and therefore wins.
    for (int off = NUM_CONSUMERS - 1; off >= 0; off--) begin
      w_idx = (int'(i_rr_ptr) + off) % NUM_CONSUMERS;
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant       = GRANT_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_controller
// Description : Round-robin arbiter of NUM_CONSUMERS LSU read/write requests
//               onto one data-memory port. One request in flight at a time.
// Ports       : clk, reset (async, active-high)
//               bus  - data_mem_controller_if.master (LSU and memory buses)
//               stat_reads / stat_writes - saturating completion counters,
//               present only when DATA_MEM_CTRL_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_controller
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_controller_if.master bus
`ifdef DATA_MEM_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_reads,
  output logic [15:0]          stat_writes
`endif
);

  localparam int GRANT_W = $clog2(NUM_CONSUMERS);

  mem_ctrl_state_t                    r_state, w_state_next;
  logic [GRANT_W-1:0]                 r_rr_ptr, w_rr_ptr_next;
  logic [GRANT_W-1:0]                 r_grant, w_grant_next;
  logic                               w_arb_valid;
  logic [GRANT_W-1:0]                 w_arb_grant;
  logic [NUM_CONSUMERS-1:0]           w_req;
  logic                               r_mem_read_valid, w_mem_read_valid_next;
  logic                               r_mem_write_valid, w_mem_write_valid_next;
  logic [ADDR_BITS-1:0]               r_mem_read_address, w_mem_read_address_next;
  logic [ADDR_BITS-1:0]               r_mem_write_address, w_mem_write_address_next;
  logic [DATA_BITS-1:0]               r_mem_write_data, w_mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]           r_read_ready, w_read_ready_next;
  logic [NUM_CONSUMERS-1:0]           r_write_ready, w_write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data, w_read_data_next;

  assign w_req = bus.consumer_read_valid | bus.consumer_write_valid;

  rr_arbiter #(
    .NUM_CONSUMERS (NUM_CONSUMERS)
  ) u_rr_arbiter (
    .i_req         (w_req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_arb_valid),
    .o_grant       (w_arb_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_rr_ptr            <= '0;
      r_grant             <= '0;
      r_mem_read_valid    <= 1'b0;
      r_mem_write_valid   <= 1'b0;
      r_mem_read_address  <= '0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      r_read_data         <= '0;
    end else begin
      r_state             <= w_state_next;
      r_rr_ptr            <= w_rr_ptr_next;
      r_grant             <= w_grant_next;
      r_mem_read_valid    <= w_mem_read_valid_next;
      r_mem_write_valid   <= w_mem_write_valid_next;
      r_mem_read_address  <= w_mem_read_address_next;
      r_mem_write_address <= w_mem_write_address_next;
      r_mem_write_data    <= w_mem_write_data_next;
      r_read_ready        <= w_read_ready_next;
      r_write_ready       <= w_write_ready_next;
      r_read_data         <= w_read_data_next;
    end
  end

  always_comb begin
    w_state_next             = r_state;
    w_rr_ptr_next            = r_rr_ptr;
    w_grant_next             = r_grant;
    w_mem_read_valid_next    = r_mem_read_valid;
    w_mem_write_valid_next   = r_mem_write_valid;
    w_mem_read_address_next  = r_mem_read_address;
    w_mem_write_address_next = r_mem_write_address;
    w_mem_write_data_next    = r_mem_write_data;
    w_read_ready_next        = r_read_ready;
    w_write_ready_next       = r_write_ready;
    w_read_data_next         = r_read_data;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_grant_next  = w_arb_grant;
          w_rr_ptr_next = (w_arb_grant == GRANT_W'(NUM_CONSUMERS - 1)) ? '0
                                                                        : w_arb_grant + 1'b1;
          // Read takes priority when a consumer presents both valids.
          if (bus.consumer_read_valid[w_arb_grant]) begin
            w_mem_read_valid_next   = 1'b1;
            w_mem_read_address_next = bus.consumer_read_address[w_arb_grant*ADDR_BITS +: ADDR_BITS];
            w_state_next            = ST_READ_WAIT;
          end else begin
            w_mem_write_valid_next   = 1'b1;
            w_mem_write_address_next = bus.consumer_write_address[w_arb_grant*ADDR_BITS +: ADDR_BITS];
            w_mem_write_data_next    = bus.consumer_write_data[w_arb_grant*DATA_BITS +: DATA_BITS];
            w_state_next             = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (bus.mem_read_ready) begin
          w_mem_read_valid_next                              = 1'b0;
          w_read_data_next[r_grant*DATA_BITS +: DATA_BITS]   = bus.mem_read_data;
          w_read_ready_next[r_grant]                         = 1'b1;
          w_state_next                                       = ST_ACK;
        end
      end
      ST_WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          w_mem_write_valid_next      = 1'b0;
          w_write_ready_next[r_grant] = 1'b1;
          w_state_next                = ST_ACK;
        end
      end
      ST_ACK: begin
        w_read_ready_next  = '0;
        w_write_ready_next = '0;
        w_state_next       = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold off re-arbitration until the served LSU has withdrawn its
        // request, otherwise its stale valid would be serviced twice.
        if (!bus.consumer_read_valid[r_grant] && !bus.consumer_write_valid[r_grant])
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.mem_read_valid       = r_mem_read_valid;
  assign bus.mem_read_address     = r_mem_read_address;
  assign bus.mem_write_valid      = r_mem_write_valid;
  assign bus.mem_write_address    = r_mem_write_address;
  assign bus.mem_write_data       = r_mem_write_data;
  assign bus.consumer_read_ready  = r_read_ready;
  assign bus.consumer_write_ready = r_write_ready;
  assign bus.consumer_read_data   = r_read_data;

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [15:0] r_stat_reads, r_stat_writes;

  // Ready bits are one-cycle pulses, so counting cycles with any bit set
  // counts completions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
    end else begin
      if (|r_read_ready && r_stat_reads != 16'hFFFF)
        r_stat_reads <= r_stat_reads + 16'd1;
      if (|r_write_ready && r_stat_writes != 16'hFFFF)
        r_stat_writes <= r_stat_writes + 16'd1;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_controller
// Description : Self-checking bench for data_mem_controller. Acts as the
//               LSUs and the data memory; a behavioural scheduler model
//               predicts grant order, addresses and returned data.
//               Stats checks are built when DATA_MEM_CTRL_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;
  import gpu_pkg::*;

  localparam int A = 8;
  localparam int D = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_controller_if #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) ifc ();

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif

  data_mem_controller #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
`ifdef DATA_MEM_CTRL_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [D-1:0]  mem_model [256];
  int            mem_lat, cur_lat, wait_cnt;
  bit            mem_lat_rand;
  bit            auto_drop [N];
  int            rd_pulses [N];
  int            wr_pulses [N];
  int            mem_rd_reqs, mem_wr_reqs;
  bit            prev_mrv, prev_mwv, rise_r, rise_w;
  logic [N-1:0]  drv_rv, drv_wv, obs_rr, obs_wr;
  int            order [$];

  // One clock of LSU + memory behaviour; observations taken at the negedge.
  task automatic cycle();
    drv_rv = ifc.consumer_read_valid;
    drv_wv = ifc.consumer_write_valid;
    @(negedge clk);
    obs_rr   = ifc.consumer_read_ready;
    obs_wr   = ifc.consumer_write_ready;
    rise_r   = ifc.mem_read_valid && !prev_mrv;
    rise_w   = ifc.mem_write_valid && !prev_mwv;
    prev_mrv = ifc.mem_read_valid;
    prev_mwv = ifc.mem_write_valid;
    if (rise_r) mem_rd_reqs++;
    if (rise_w) mem_wr_reqs++;
    if (rise_r || rise_w) cur_lat = mem_lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
    for (int i = 0; i < N; i++) begin
      if (obs_rr[i]) begin rd_pulses[i]++; order.push_back(i); end
      if (obs_wr[i]) begin wr_pulses[i]++; order.push_back(i); end
    end
    if (ifc.mem_read_ready || ifc.mem_write_ready) begin
      ifc.mem_read_ready  = 1'b0;
      ifc.mem_write_ready = 1'b0;
      ifc.mem_read_data   = D'($urandom);
      wait_cnt            = 0;
    end else if (ifc.mem_read_valid || ifc.mem_write_valid) begin
      if (wait_cnt >= cur_lat) begin
        if (ifc.mem_read_valid) begin
          ifc.mem_read_ready = 1'b1;
          ifc.mem_read_data  = mem_model[ifc.mem_read_address];
        end else begin
          ifc.mem_write_ready = 1'b1;
          mem_model[ifc.mem_write_address] = ifc.mem_write_data;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    for (int i = 0; i < N; i++)
      if (auto_drop[i] && (obs_rr[i] || obs_wr[i])) begin
        ifc.consumer_read_valid[i]  = 1'b0;
        ifc.consumer_write_valid[i] = 1'b0;
      end
  endtask

  task automatic clear_tb_state();
    ifc.consumer_read_valid    = '0;
    ifc.consumer_write_valid   = '0;
    ifc.consumer_read_address  = '0;
    ifc.consumer_write_address = '0;
    ifc.consumer_write_data    = '0;
    ifc.mem_read_ready         = 1'b0;
    ifc.mem_write_ready        = 1'b0;
    ifc.mem_read_data          = '0;
    for (int i = 0; i < N; i++) begin
      auto_drop[i] = 1'b1;
      rd_pulses[i] = 0;
      wr_pulses[i] = 0;
    end
    mem_rd_reqs = 0; mem_wr_reqs = 0;
    mem_lat = 0; cur_lat = 0; mem_lat_rand = 1'b0; wait_cnt = 0;
    prev_mrv = 1'b0; prev_mwv = 1'b0;
    order.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_tb_state();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_tb_state();
    ifc.consumer_read_valid   = N'($urandom) | 4'b0001;
    ifc.consumer_read_address = N*A'($urandom);
    ifc.mem_read_ready        = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifc.mem_read_valid, ifc.mem_write_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mem_valid: got %b expected 00", {ifc.mem_read_valid, ifc.mem_write_valid});
    end
    n_checks++;
    if ({ifc.mem_read_address, ifc.mem_write_address, ifc.mem_write_data} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0", ifc.mem_read_address, ifc.mem_write_address, ifc.mem_write_data);
    end
    n_checks++;
    if ({ifc.consumer_read_ready, ifc.consumer_write_ready, ifc.consumer_read_data} !== '0) begin
      n_fail++; $display("FAIL reset_consumer: got rr=%b wr=%b rd=%h expected 0", ifc.consumer_read_ready, ifc.consumer_write_ready, ifc.consumer_read_data);
    end
    clear_tb_state();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int c_rise, c_pulse;
    logic [D-1:0] slot;
    do_reset();
    mem_lat = 2;
    mem_model[8'h3C] = 8'hA5;
    ifc.consumer_read_address[2*A +: A] = 8'h3C;
    ifc.consumer_read_valid[2] = 1'b1;
    c_rise = -1; c_pulse = -1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (rise_r) c_rise = c;
      if (obs_rr[2] && c_pulse < 0) begin
        c_pulse = c;
        slot = ifc.consumer_read_data[2*D +: D];
        n_checks++;
        if (slot !== 8'hA5) begin
          n_fail++; $display("FAIL rd_data_with_ready: got %h expected a5", slot);
        end
      end
      if (ifc.mem_read_valid) begin
        n_checks++;
        if (ifc.mem_read_address !== 8'h3C) begin
          n_fail++; $display("FAIL rd_mem_addr: got %h expected 3c", ifc.mem_read_address);
        end
      end
    end
    n_checks++;
    if (c_pulse - c_rise !== 3 || c_rise < 0) begin
      n_fail++; $display("FAIL rd_latency: got rise=%0d pulse=%0d expected pulse-rise=3", c_rise, c_pulse);
    end
    n_checks++;
    if (rd_pulses[2] !== 1 || mem_rd_reqs !== 1 || order.size() !== 1) begin
      n_fail++; $display("FAIL rd_pulse_count: got pulses=%0d reqs=%0d total=%0d expected 1/1/1", rd_pulses[2], mem_rd_reqs, order.size());
    end
    n_checks++;
    if (ifc.consumer_read_data !== {8'h00, 8'hA5, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL rd_slots: got %h expected 00a50000", ifc.consumer_read_data);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    mem_lat = 1;
    mem_model[8'h10] = 8'h00;
    ifc.consumer_write_address[0 +: A] = 8'h10;
    ifc.consumer_write_data[0 +: D]    = 8'h7E;
    ifc.consumer_write_valid[0]        = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (ifc.mem_write_valid) begin
        n_checks++;
        if (ifc.mem_write_address !== 8'h10 || ifc.mem_write_data !== 8'h7E) begin
          n_fail++; $display("FAIL wr_mem_bus: got %h/%h expected 10/7e", ifc.mem_write_address, ifc.mem_write_data);
        end
      end
    end
    n_checks++;
    if (wr_pulses[0] !== 1 || mem_wr_reqs !== 1 || mem_rd_reqs !== 0 || order.size() !== 1) begin
      n_fail++; $display("FAIL wr_pulse_count: got pulses=%0d wreqs=%0d rreqs=%0d expected 1/1/0", wr_pulses[0], mem_wr_reqs, mem_rd_reqs);
    end
    n_checks++;
    if (mem_model[8'h10] !== 8'h7E) begin
      n_fail++; $display("FAIL wr_mem_content: got %h expected 7e", mem_model[8'h10]);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) begin
      ifc.consumer_read_address[i*A +: A] = A'(8'h40 + i);
      ifc.consumer_read_valid[i] = 1'b1;
    end
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (obs_rr[i]) begin
          n_checks++;
          if (ifc.consumer_read_data[i*D +: D] !== mem_model[8'h40 + i]) begin
            n_fail++; $display("FAIL rr_data%0d: got %h expected %h", i, ifc.consumer_read_data[i*D +: D], mem_model[8'h40 + i]);
          end
        end
    end
    repeat (4) cycle();
    ifc.consumer_read_valid[1] = 1'b1;
    ifc.consumer_read_valid[0] = 1'b1;
    for (int c = 0; c < 40 && order.size() < 6; c++) cycle();
    n_checks++;
    if (order.size() !== 6) begin
      n_fail++; $display("FAIL rr_count: got %0d services expected 6", order.size());
    end
    for (int k = 0; k < 6 && k < order.size(); k++) begin
      n_checks++;
      if (order[k] !== exp_order[k]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_stale_valid();
    do_reset();
    auto_drop[1] = 1'b0;
    mem_model[8'h22] = 8'hC3;
    ifc.consumer_read_address[1*A +: A] = 8'h22;
    ifc.consumer_read_valid[1] = 1'b1;
    for (int c = 0; c < 20 && rd_pulses[1] == 0; c++) cycle();
    repeat (3) cycle();
    n_checks++;
    if (mem_rd_reqs !== 1 || ifc.mem_read_valid !== 1'b0) begin
      n_fail++; $display("FAIL stale_held: got reqs=%0d valid=%b expected 1/0", mem_rd_reqs, ifc.mem_read_valid);
    end
    ifc.consumer_read_valid[1] = 1'b0;
    repeat (6) cycle();
    n_checks++;
    if (mem_rd_reqs !== 1 || rd_pulses[1] !== 1) begin
      n_fail++; $display("FAIL stale_after_drop: got reqs=%0d pulses=%0d expected 1/1", mem_rd_reqs, rd_pulses[1]);
    end
    n_checks++;
    if (ifc.consumer_read_data[1*D +: D] !== 8'hC3) begin
      n_fail++; $display("FAIL stale_data: got %h expected c3", ifc.consumer_read_data[1*D +: D]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_model[8'h05] = 8'h5A;
    mem_model[8'h31] = 8'h31 ^ 8'hFF;
    mem_model[8'h33] = 8'h33 ^ 8'hFF;
    ifc.consumer_read_address[0 +: A] = 8'h05;
    ifc.consumer_read_valid[0] = 1'b1;
    for (int c = 0; c < 20 && rd_pulses[0] == 0; c++) cycle();
    repeat (4) cycle();
    // Serving 2 leaves the pointer at 3; a kept pointer would pick 3 next.
    mem_lat = 10;
    ifc.consumer_read_address[2*A +: A] = 8'h31;
    ifc.consumer_read_valid[2] = 1'b1;
    for (int c = 0; c < 20 && mem_rd_reqs == 0; c++) cycle();
    ifc.consumer_read_address[3*A +: A] = 8'h33;
    ifc.consumer_read_valid[3] = 1'b1;
    repeat (2) cycle();
    reset = 1'b1;
    order.delete();
    cycle();
    n_checks++;
    if ({ifc.mem_read_valid, ifc.mem_write_valid, ifc.mem_read_address, ifc.mem_write_address, ifc.mem_write_data} !== '0) begin
      n_fail++; $display("FAIL midrst_mem: got rv=%b wv=%b ra=%h expected 0", ifc.mem_read_valid, ifc.mem_write_valid, ifc.mem_read_address);
    end
    n_checks++;
    if ({ifc.consumer_read_ready, ifc.consumer_write_ready, ifc.consumer_read_data} !== '0) begin
      n_fail++; $display("FAIL midrst_consumer: got rr=%b wr=%b rd=%h expected 0", ifc.consumer_read_ready, ifc.consumer_write_ready, ifc.consumer_read_data);
    end
    reset   = 1'b0;
    mem_lat = 0;
    for (int c = 0; c < 40 && order.size() < 2; c++) cycle();
    n_checks++;
    if (order.size() !== 2 || order[0] !== 2 || order[1] !== 3) begin
      n_fail++; $display("FAIL midrst_regrant: got n=%0d first=%0d expected 2 services, order 2,3", order.size(), (order.size() > 0) ? order[0] : -1);
    end
    n_checks++;
    if (ifc.consumer_read_data[2*D +: D] !== mem_model[8'h31] || ifc.consumer_read_data[3*D +: D] !== mem_model[8'h33]) begin
      n_fail++; $display("FAIL midrst_data: got %h expected slots2/3=%h/%h", ifc.consumer_read_data, mem_model[8'h31], mem_model[8'h33]);
    end
  endtask

  task automatic test_random();
    int           ptr, g, exp_g, served, kind;
    int           idle [N];
    bit           busy, exp_rd;
    logic [A-1:0] exp_addr;
    logic [D-1:0] exp_wd, exp_rdata;
    logic [D-1:0] slots [N];
    logic [N-1:0] req, onehot;
    do_reset();
    mem_lat_rand = 1'b1;
    ptr = 0; busy = 1'b0; served = 0; exp_g = 0; exp_rd = 1'b0;
    exp_addr = '0; exp_wd = '0; exp_rdata = '0;
    for (int i = 0; i < N; i++) begin slots[i] = '0; idle[i] = 3; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      cycle();
      if (rise_r || rise_w) begin
        req = drv_rv | drv_wv;
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(ptr + k) % N]) g = (ptr + k) % N;
        n_checks++;
        if (g < 0 || busy) begin
          n_fail++; $display("FAIL rnd_grant: unexpected memory request (req=%b busy=%b)", req, busy);
        end else begin
          exp_g    = g;
          exp_rd   = drv_rv[g];
          busy     = 1'b1;
          ptr      = (g + 1) % N;
          exp_addr = exp_rd ? ifc.consumer_read_address[g*A +: A] : ifc.consumer_write_address[g*A +: A];
          exp_wd   = ifc.consumer_write_data[g*D +: D];
          exp_rdata = mem_model[exp_addr];
          n_checks++;
          if (rise_r !== exp_rd || rise_w === exp_rd) begin
            n_fail++; $display("FAIL rnd_kind: got read=%b write=%b expected read=%b for consumer %0d", rise_r, rise_w, exp_rd, g);
          end
        end
      end
      if (busy && ifc.mem_read_valid) begin
        n_checks++;
        if (ifc.mem_read_address !== exp_addr) begin
          n_fail++; $display("FAIL rnd_raddr: got %h expected %h", ifc.mem_read_address, exp_addr);
        end
      end
      if (busy && ifc.mem_write_valid) begin
        n_checks++;
        if (ifc.mem_write_address !== exp_addr || ifc.mem_write_data !== exp_wd) begin
          n_fail++; $display("FAIL rnd_wbus: got %h/%h expected %h/%h", ifc.mem_write_address, ifc.mem_write_data, exp_addr, exp_wd);
        end
      end
      if (obs_rr != '0 || obs_wr != '0) begin
        onehot = N'(1) << exp_g;
        n_checks++;
        if (!busy || obs_rr !== (exp_rd ? onehot : '0) || obs_wr !== (exp_rd ? '0 : onehot)) begin
          n_fail++; $display("FAIL rnd_ready: got rr=%b wr=%b expected consumer %0d read=%b busy=%b", obs_rr, obs_wr, exp_g, exp_rd, busy);
        end else begin
          if (exp_rd) slots[exp_g] = exp_rdata;
          busy = 1'b0;
          served++;
        end
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (ifc.consumer_read_data[i*D +: D] !== slots[i]) begin
          n_fail++; $display("FAIL rnd_slot%0d: got %h expected %h", i, ifc.consumer_read_data[i*D +: D], slots[i]);
          slots[i] = ifc.consumer_read_data[i*D +: D];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ifc.consumer_read_valid[i] || ifc.consumer_write_valid[i]) idle[i] = 0;
        else idle[i]++;
        if (cyc < 500 && idle[i] >= 3 && $urandom_range(0, 3) == 0) begin
          kind = int'($urandom_range(0, 4));
          ifc.consumer_read_address[i*A +: A]  = A'($urandom_range(0, 15));
          ifc.consumer_write_address[i*A +: A] = A'($urandom_range(0, 15));
          ifc.consumer_write_data[i*D +: D]    = D'($urandom);
          if (kind < 2 || kind == 4) ifc.consumer_read_valid[i] = 1'b1;
          if (kind >= 2) ifc.consumer_write_valid[i] = 1'b1;
          idle[i] = 0;
        end
      end
    end
    n_checks++;
    if ((ifc.consumer_read_valid | ifc.consumer_write_valid) !== '0 || busy) begin
      n_fail++; $display("FAIL rnd_drain: got pending rv=%b wv=%b busy=%b expected none", ifc.consumer_read_valid, ifc.consumer_write_valid, busy);
    end
    n_checks++;
    if (served < 30) begin
      n_fail++; $display("FAIL rnd_served: got %0d completions expected at least 30", served);
    end
  endtask

`ifdef DATA_MEM_CTRL_STATS_EN
  task automatic test_stats();
    int cons [5];
    bit isrd [5];
    cons = '{0, 1, 2, 3, 1};
    isrd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int r = 0; r < 5; r++) begin
      order.delete();
      ifc.consumer_read_address[cons[r]*A +: A]  = A'(r);
      ifc.consumer_write_address[cons[r]*A +: A] = A'(r + 8);
      if (isrd[r]) ifc.consumer_read_valid[cons[r]] = 1'b1;
      else         ifc.consumer_write_valid[cons[r]] = 1'b1;
      for (int c = 0; c < 20 && order.size() == 0; c++) cycle();
      repeat (3) cycle();
    end
    n_checks++;
    if (stat_reads !== 16'd3 || stat_writes !== 16'd2) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d expected 3/2", stat_reads, stat_writes);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stat_reads !== 16'd0 || stat_writes !== 16'd0) begin
      n_fail++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_reads, stat_writes);
    end
    reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem_model[i] = D'($urandom);
    clear_tb_state();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_stale_valid();
    test_reset_mid();
    test_random();
`ifdef DATA_MEM_CTRL_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
